// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE command FSM, tick prescaler,
// 4-digit BCD cascade with sticky wrap flag, and lap-hold display latch.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        clear_i,
  input  logic        lap_i,
  output logic [15:0] cnt_o,
  output logic [1:0]  state_o,
  output logic        hold_o,
  output logic        ovf_o
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_pre;
  logic [15:0]   r_digits;
  logic [15:0]   r_latch;
  logic [15:0]   r_cnt;
  logic          r_hold;
  logic          r_ovf;

  state_t        w_state_nxt;
  logic [PW-1:0] w_pre_nxt;
  logic [15:0]   w_digits_nxt;
  logic [15:0]   w_latch_nxt;
  logic [15:0]   w_inc;
  logic          w_hold_nxt;
  logic          w_ovf_nxt;
  logic          w_tick;
  logic          w_wrap;

  assign w_tick = (r_state == ST_RUN) && (r_pre == PRE_MAX);

  // Ripple the tick through all four digits within one cycle; the final
  // carry out of the thousands digit marks the 9999 -> 0000 wrap.
  always_comb begin
    logic c;
    c     = w_tick;
    w_inc = r_digits;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r_digits[4*i +: 4] >= 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_digits[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    w_wrap = c;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pre_nxt    = r_pre;
    w_digits_nxt = r_digits;
    w_latch_nxt  = r_latch;
    w_hold_nxt   = r_hold;
    w_ovf_nxt    = r_ovf;
    if (clear_i) begin
      w_state_nxt  = ST_IDLE;
      w_pre_nxt    = '0;
      w_digits_nxt = '0;
      w_hold_nxt   = 1'b0;
      w_ovf_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          w_pre_nxt    = w_tick ? '0 : r_pre + 1'b1;
          w_digits_nxt = w_inc;
          if (w_wrap) w_ovf_nxt = 1'b1;
          if (stop_i) w_state_nxt = ST_PAUSE;
          // Capture the pre-increment value on the hold-engaging toggle.
          if (lap_i) begin
            w_hold_nxt = ~r_hold;
            if (!r_hold) w_latch_nxt = r_digits;
          end
        end
        ST_PAUSE: begin
          if (start_i && !stop_i) w_state_nxt = ST_RUN;
          if (lap_i) w_hold_nxt = 1'b0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_pre    <= '0;
      r_digits <= '0;
      r_latch  <= '0;
      r_cnt    <= '0;
      r_hold   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pre    <= w_pre_nxt;
      r_digits <= w_digits_nxt;
      r_latch  <= w_latch_nxt;
      r_cnt    <= w_hold_nxt ? w_latch_nxt : w_digits_nxt;
      r_hold   <= w_hold_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  assign cnt_o   = r_cnt;
  assign state_o = r_state;
  assign hold_o  = r_hold;
  assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios then random commands, every
// cycle compared against an integer-valued behavioural stopwatch model.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int BUDGET   = 60000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        lap_i = 1'b0;
  logic [15:0] cnt_o;
  logic [1:0]  state_o;
  logic        hold_o;
  logic        ovf_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: decimal count value, state 0 idle / 1 run / 2 pause.
  int m_state, m_cnt, m_pre, m_hold, m_latch, m_ovf;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .stop_i  (stop_i),
    .clear_i (clear_i),
    .lap_i   (lap_i),
    .cnt_o   (cnt_o),
    .state_o (state_o),
    .hold_o  (hold_o),
    .ovf_o   (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached (%0d/%0d checks passed)", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_pre = 0; m_hold = 0; m_latch = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit cl, input bit lp);
    bit tick;
    if (cl) begin
      model_reset();
    end else begin
      tick = (m_state == 1) && (m_pre == TICK_DIV - 1);
      if (m_state == 1) m_pre = tick ? 0 : m_pre + 1;
      if (m_state == 1 && lp) begin
        if (m_hold == 0) m_latch = m_cnt;
        m_hold = 1 - m_hold;
      end else if (m_state == 2 && lp) begin
        m_hold = 0;
      end
      if (tick) begin
        if (m_cnt == 9999) m_ovf = 1;
        m_cnt = (m_cnt + 1) % 10000;
      end
      case (m_state)
        0: if (st) m_state = 1;
        1: if (sp) m_state = 2;
        2: if (st && !sp) m_state = 1;
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic check_outputs();
    check("cnt",   32'(cnt_o),   32'(to_bcd(m_hold != 0 ? m_latch : m_cnt)));
    check("state", 32'(state_o), 32'(m_state));
    check("hold",  32'(hold_o),  32'(m_hold));
    check("ovf",   32'(ovf_o),   32'(m_ovf));
  endtask

  task automatic cycle(input bit st, input bit sp, input bit cl, input bit lp);
    @(negedge clk_i);
    start_i = st; stop_i = sp; clear_i = cl; lap_i = lp;
    @(posedge clk_i);
    model_step(st, sp, cl, lp);
    #1;
    check_outputs();
    start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0; lap_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic wait_cnt(input int target, input string tag);
    int i;
    for (i = 0; i < BUDGET && m_cnt != target; i++) cycle(0, 0, 0, 0);
    n_checks++;
    assert (m_cnt == target) n_pass++;
    else $error("FAIL %s: timeout after %0d cycles, count %0d expected %0d", tag, i, m_cnt, target);
  endtask

  task automatic wait_pre(input int target, input string tag);
    int i;
    for (i = 0; i < 2 * TICK_DIV && m_pre != target; i++) cycle(0, 0, 0, 0);
    n_checks++;
    assert (m_pre == target) n_pass++;
    else $error("FAIL %s: timeout after %0d cycles, phase %0d expected %0d", tag, i, m_pre, target);
  endtask

  initial begin
    model_reset();
    #3;
    check_outputs();
    @(negedge clk_i);
    rst_i = 1'b0;

    // Idle ignores stop and lap.
    cycle(0, 1, 0, 1);
    cycle(0, 0, 0, 0);
    check("idle_state", 32'(state_o), 32'h0);

    // Start latency and redundant start.
    cycle(1, 0, 0, 0);
    check("start_state", 32'(state_o), 32'h1);
    idle(3);
    check("pre_first_tick", 32'(cnt_o), 32'h0000);
    idle(1);
    check("first_tick", 32'(cnt_o), 32'h0001);
    idle(4);
    check("second_tick", 32'(cnt_o), 32'h0002);
    cycle(1, 0, 0, 0);
    check("start_in_run", 32'(state_o), 32'h1);

    // Asynchronous reset in mid-cycle with a non-zero count.
    wait_cnt(42, "reach_42");
    check("live_42", 32'(cnt_o), 32'h0042);
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk_i);
    rst_i = 1'b0;

    // Pause two cycles into a period, resume continues the partial period.
    cycle(1, 0, 0, 0);
    wait_cnt(5, "reach_5");
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    check("pause_state", 32'(state_o), 32'h2);
    idle(20);
    check("pause_frozen", 32'(cnt_o), 32'h0005);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("resume_partial", 32'(cnt_o), 32'h0005);
    cycle(0, 0, 0, 0);
    check("resume_tick", 32'(cnt_o), 32'h0006);

    // Lap hold, release, and forced release in pause.
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    wait_cnt(15, "reach_15");
    cycle(0, 0, 0, 1);
    check("lap_hold", 32'(hold_o), 32'h1);
    wait_cnt(20, "reach_20");
    check("lap_frozen", 32'(cnt_o), 32'h0015);
    cycle(0, 0, 0, 1);
    check("lap_release", 32'(cnt_o), 32'h0020);
    check("lap_release_hold", 32'(hold_o), 32'h0);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    check("lap_hold_paused", 32'(hold_o), 32'h1);
    cycle(0, 0, 0, 1);
    check("lap_in_pause", 32'(hold_o), 32'h0);

    // Simultaneous events.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 0);
    check("clear_start_state", 32'(state_o), 32'h0);
    check("clear_start_cnt", 32'(cnt_o), 32'h0000);
    cycle(1, 0, 0, 0);
    wait_pre(TICK_DIV - 1, "reach_phase");
    cycle(0, 1, 0, 0);
    check("stop_tick_cnt", 32'(cnt_o), 32'h0001);
    check("stop_tick_state", 32'(state_o), 32'h2);
    cycle(1, 1, 0, 0);
    check("start_stop_pause", 32'(state_o), 32'h2);

    // Full cascade and wrap.
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    wait_cnt(999, "reach_999");
    idle(TICK_DIV);
    check("cascade_1000", 32'(cnt_o), 32'h1000);
    wait_cnt(9999, "reach_9999");
    check("ovf_before_wrap", 32'(ovf_o), 32'h0);
    idle(TICK_DIV);
    check("wrap_cnt", 32'(cnt_o), 32'h0000);
    check("wrap_ovf", 32'(ovf_o), 32'h1);
    idle(10 * TICK_DIV);
    check("ovf_sticky", 32'(ovf_o), 32'h1);
    check("post_wrap_cnt", 32'(cnt_o), 32'h0010);
    cycle(0, 0, 1, 0);
    check("ovf_cleared", 32'(ovf_o), 32'h0);

    // Random command mix.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
